// File: rtl/eth_pkg.sv
// Shared types and constants for the RMII MAC datapath and the MDIO management engine.
// md_frame builds the 64-bit management frame that is shifted out MSB first.
package eth_pkg;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic {MD_IDLE, MD_SHIFT} md_state_t;

  localparam int MDC_DIV      = 16;
  localparam int PREAMBLE_LEN = 32;
  localparam int FRAME_LEN    = PREAMBLE_LEN + 32;
  // first turnaround bit: ST(2) + OP(2) + PHYAD(5) + REGAD(5) after the preamble
  localparam int TA_BIT       = PREAMBLE_LEN + 14;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  function automatic logic [FRAME_LEN-1:0] md_frame(
    input logic        mode,
    input logic [4:0]  phy_addr,
    input logic [4:0]  reg_addr,
    input logic [15:0] data
  );
    logic [1:0]  op;
    logic [1:0]  ta;
    logic [15:0] payload;
    op      = mode ? OP_WRITE : OP_READ;
    ta      = mode ? 2'b10 : 2'b00;
    payload = mode ? data : 16'h0000;
    return {{PREAMBLE_LEN{1'b1}}, 2'b01, op, phy_addr, reg_addr, ta, payload};
  endfunction

endpackage

// File: rtl/rmii_ethernet_if.sv
// Host-side word interface of the RMII MAC: transmit/receive words and MDIO requests.
// The host drives through master; the MAC core sits on slave.
interface rmii_ethernet_if;
  logic [31:0] tx_buf;
  logic        tx_valid;
  logic        tx_new_data;
  logic        tx_empty;
  logic [31:0] rx_buf;
  logic        rx_full;
  logic        MD_start;
  logic        MD_mode;
  logic [4:0]  MD_addr;
  logic [4:0]  MD_reg_addr;
  logic [15:0] MD_data_to;
  logic [15:0] MD_data_from;
  logic        MD_done;

  modport master (
    output tx_buf, tx_valid, tx_new_data, MD_start, MD_mode, MD_addr, MD_reg_addr, MD_data_to,
    input  tx_empty, rx_buf, rx_full, MD_data_from, MD_done
  );

  modport slave (
    input  tx_buf, tx_valid, tx_new_data, MD_start, MD_mode, MD_addr, MD_reg_addr, MD_data_to,
    output tx_empty, rx_buf, rx_full, MD_data_from, MD_done
  );
endinterface

// File: rtl/mdio_master.sv
// Clause-22 MDIO management engine: mdc = clk/MDC_DIV, mdio_o changes on mdc fall,
// mdio_i sampled on mdc rise; one 64-bit frame per request.
module mdio_master
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        md_start,
  input  logic        md_mode,
  input  logic [4:0]  md_addr,
  input  logic [4:0]  md_reg_addr,
  input  logic [15:0] md_data_to,
  output logic [15:0] md_data_from,
  output logic        md_done,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int PHASE_W = $clog2(MDC_DIV);
  localparam int BIT_W   = $clog2(FRAME_LEN);

  md_state_t              state_reg;
  logic [FRAME_LEN-1:0]   frame_reg;
  logic [PHASE_W-1:0]     phase_reg;
  logic [BIT_W-1:0]       bit_cnt_reg;
  logic                   mode_reg;
  logic [15:0]            rd_shift_reg;
  logic [15:0]            md_data_from_reg;
  logic                   md_done_reg;
  logic                   mdc_reg;
  logic                   mdio_o_reg;
  logic                   mdio_oe_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= MD_IDLE;
      frame_reg        <= '0;
      phase_reg        <= '0;
      bit_cnt_reg      <= '0;
      mode_reg         <= 1'b0;
      rd_shift_reg     <= '0;
      md_data_from_reg <= '0;
      md_done_reg      <= 1'b0;
      mdc_reg          <= 1'b0;
      mdio_o_reg       <= 1'b1;
      mdio_oe_reg      <= 1'b0;
    end else begin
      md_done_reg <= 1'b0;
      case (state_reg)
        MD_IDLE: begin
          mdc_reg     <= 1'b0;
          mdio_o_reg  <= 1'b1;
          mdio_oe_reg <= 1'b0;
          if (md_start) begin
            frame_reg   <= md_frame(md_mode, md_addr, md_reg_addr, md_data_to);
            mode_reg    <= md_mode;
            phase_reg   <= '0;
            bit_cnt_reg <= '0;
            mdio_o_reg  <= 1'b1;  // first preamble bit
            mdio_oe_reg <= 1'b1;
            state_reg   <= MD_SHIFT;
          end
        end
        MD_SHIFT: begin
          phase_reg <= phase_reg + PHASE_W'(1);
          if (phase_reg == PHASE_W'(MDC_DIV / 2 - 1)) begin
            mdc_reg      <= 1'b1;
            rd_shift_reg <= {rd_shift_reg[14:0], mdio_i};
          end else if (phase_reg == PHASE_W'(MDC_DIV - 1)) begin
            mdc_reg <= 1'b0;
            if (bit_cnt_reg == BIT_W'(FRAME_LEN - 1)) begin
              state_reg   <= MD_IDLE;
              md_done_reg <= 1'b1;
              mdio_o_reg  <= 1'b1;
              mdio_oe_reg <= 1'b0;
              if (!mode_reg) begin
                md_data_from_reg <= rd_shift_reg;
              end
            end else begin
              // reads release the line from the turnaround onwards
              bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
              frame_reg   <= {frame_reg[FRAME_LEN-2:0], 1'b0};
              mdio_o_reg  <= frame_reg[FRAME_LEN-2];
              mdio_oe_reg <= mode_reg || (bit_cnt_reg < BIT_W'(TA_BIT - 1));
            end
          end
        end
        default: state_reg <= MD_IDLE;
      endcase
    end
  end

  assign md_data_from = md_data_from_reg;
  assign md_done      = md_done_reg;
  assign mdc          = mdc_reg;
  assign mdio_o       = mdio_o_reg;
  assign mdio_oe      = mdio_oe_reg;

endmodule

// File: rtl/rmii_ethernet.sv
// RMII MAC word datapath: 32-bit words out/in as dibits MSB pair first, plus MDIO engine.
// No preamble/SFD/FCS handling; the host supplies and receives raw words.
module rmii_ethernet
  import eth_pkg::*;
(
  input  logic       clk_25_mhz,
  input  logic       rst,
  output logic [1:0] rmii_tx_d,
  output logic       rmii_tx_en,
  input  logic [1:0] rmii_rx_d,
  input  logic       rmii_crs_dv,
  input  logic       rmii_rx_er,
  output logic       mdc,
  output logic       mdio_o,
  output logic       mdio_oe,
  input  logic       mdio_i,
  rmii_ethernet_if.slave host
);

  tx_state_t   tx_state_reg;
  logic [31:0] tx_shift_reg;
  logic [31:0] tx_hold_reg;
  logic        tx_hold_full_reg;
  logic [3:0]  tx_cnt_reg;
  logic [1:0]  tx_d_reg;
  logic        tx_en_reg;

  // tx_cnt_reg counts dibits already put on the wire; it wraps to 0 after the 16th
  always_ff @(posedge clk_25_mhz) begin
    if (rst) begin
      tx_state_reg     <= TX_IDLE;
      tx_shift_reg     <= '0;
      tx_hold_reg      <= '0;
      tx_hold_full_reg <= 1'b0;
      tx_cnt_reg       <= '0;
      tx_d_reg         <= 2'b00;
      tx_en_reg        <= 1'b0;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          tx_hold_full_reg <= 1'b0;
          if (host.tx_valid) begin
            tx_d_reg     <= host.tx_buf[31:30];
            tx_shift_reg <= {host.tx_buf[29:0], 2'b00};
            tx_cnt_reg   <= 4'd1;
            tx_en_reg    <= 1'b1;
            tx_state_reg <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_cnt_reg != 4'd0) begin
            tx_d_reg     <= tx_shift_reg[31:30];
            tx_shift_reg <= {tx_shift_reg[29:0], 2'b00};
            tx_cnt_reg   <= tx_cnt_reg + 4'd1;
            if (host.tx_new_data && !tx_hold_full_reg) begin
              tx_hold_reg      <= host.tx_buf;
              tx_hold_full_reg <= 1'b1;
            end
          end else if (tx_hold_full_reg) begin
            tx_d_reg         <= tx_hold_reg[31:30];
            tx_shift_reg     <= {tx_hold_reg[29:0], 2'b00};
            tx_cnt_reg       <= 4'd1;
            tx_hold_full_reg <= 1'b0;
          end else if (host.tx_new_data) begin
            // word offered exactly at the boundary goes straight to the wire
            tx_d_reg     <= host.tx_buf[31:30];
            tx_shift_reg <= {host.tx_buf[29:0], 2'b00};
            tx_cnt_reg   <= 4'd1;
          end else begin
            tx_state_reg <= TX_IDLE;
            tx_en_reg    <= 1'b0;
            tx_d_reg     <= 2'b00;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  assign rmii_tx_d     = tx_d_reg;
  assign rmii_tx_en    = tx_en_reg;
  assign host.tx_empty = !tx_hold_full_reg;

  logic [31:0] rx_shift_reg;
  logic [31:0] rx_buf_reg;
  logic [3:0]  rx_cnt_reg;
  logic        rx_err_reg;
  logic        rx_full_reg;

  // an error poisons every word until carrier drops
  always_ff @(posedge clk_25_mhz) begin
    if (rst) begin
      rx_shift_reg <= '0;
      rx_buf_reg   <= '0;
      rx_cnt_reg   <= '0;
      rx_err_reg   <= 1'b0;
      rx_full_reg  <= 1'b0;
    end else begin
      rx_full_reg <= 1'b0;
      if (!rmii_crs_dv) begin
        rx_cnt_reg <= '0;
        rx_err_reg <= 1'b0;
      end else begin
        rx_shift_reg <= {rx_shift_reg[29:0], rmii_rx_d};
        rx_cnt_reg   <= rx_cnt_reg + 4'd1;
        rx_err_reg   <= rx_err_reg | rmii_rx_er;
        if (rx_cnt_reg == 4'd15 && !(rx_err_reg || rmii_rx_er)) begin
          rx_buf_reg  <= {rx_shift_reg[29:0], rmii_rx_d};
          rx_full_reg <= 1'b1;
        end
      end
    end
  end

  assign host.rx_buf  = rx_buf_reg;
  assign host.rx_full = rx_full_reg;

  logic [15:0] md_data_from_w;
  logic        md_done_w;

  mdio_master u_mdio (
    .clk          (clk_25_mhz),
    .rst          (rst),
    .md_start     (host.MD_start),
    .md_mode      (host.MD_mode),
    .md_addr      (host.MD_addr),
    .md_reg_addr  (host.MD_reg_addr),
    .md_data_to   (host.MD_data_to),
    .md_data_from (md_data_from_w),
    .md_done      (md_done_w),
    .mdc          (mdc),
    .mdio_o       (mdio_o),
    .mdio_oe      (mdio_oe),
    .mdio_i       (mdio_i)
  );

  assign host.MD_data_from = md_data_from_w;
  assign host.MD_done      = md_done_w;

endmodule

// File: tb/tb_rmii_ethernet.sv
// Directed bench for rmii_ethernet: TX single/chained words, RX words with drop and error,
// MDIO write/read frames, and reset in the middle of activity.
module tb_rmii_ethernet;

  logic       clk_25_mhz = 1'b0;
  logic       rst;
  logic [1:0] rmii_tx_d;
  logic       rmii_tx_en;
  logic [1:0] rmii_rx_d;
  logic       rmii_crs_dv;
  logic       rmii_rx_er;
  logic       mdc;
  logic       mdio_o;
  logic       mdio_oe;
  logic       mdio_i;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_full_cnt = 0;
  int md_done_cnt = 0;

  always #20 clk_25_mhz = ~clk_25_mhz;

  rmii_ethernet_if host_if ();

  rmii_ethernet dut (
    .clk_25_mhz  (clk_25_mhz),
    .rst         (rst),
    .rmii_tx_d   (rmii_tx_d),
    .rmii_tx_en  (rmii_tx_en),
    .rmii_rx_d   (rmii_rx_d),
    .rmii_crs_dv (rmii_crs_dv),
    .rmii_rx_er  (rmii_rx_er),
    .mdc         (mdc),
    .mdio_o      (mdio_o),
    .mdio_oe     (mdio_oe),
    .mdio_i      (mdio_i),
    .host        (host_if)
  );

  always @(posedge clk_25_mhz) begin
    if (host_if.rx_full) rx_full_cnt++;
    if (host_if.MD_done) md_done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25_mhz);
    #1;
  endtask

  task automatic wait_mdc_rise(output bit ok, output int n);
    logic prev;
    ok = 1'b0;
    n  = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      prev = mdc;
      tick();
      n++;
      if (!prev && mdc) ok = 1'b1;
    end
  endtask

  task automatic send_rx_word(input logic [31:0] w, input int n, input int er_at);
    for (int i = 0; i < n; i++) begin
      rmii_rx_d   = w[31-2*i -: 2];
      rmii_crs_dv = 1'b1;
      rmii_rx_er  = (i == er_at);
      tick();
    end
    rmii_rx_er = 1'b0;
  endtask

  initial begin
    logic [31:0] got32;
    logic [63:0] got64;
    logic [63:0] oe64;
    logic [15:0] rd_val;
    logic        en_all;
    logic        e15;
    logic        e16;
    bit          ok;
    bit          all_ok;
    int          n;
    int          first_n;
    int          cnt_before;

    rst = 1'b1;
    rmii_rx_d = 2'b00; rmii_crs_dv = 1'b0; rmii_rx_er = 1'b0; mdio_i = 1'b1;
    host_if.tx_buf = '0; host_if.tx_valid = 1'b0; host_if.tx_new_data = 1'b0;
    host_if.MD_start = 1'b0; host_if.MD_mode = 1'b0; host_if.MD_addr = '0;
    host_if.MD_reg_addr = '0; host_if.MD_data_to = '0;
    repeat (3) tick();

    check("rst_tx_en", 64'(rmii_tx_en), 64'd0);
    check("rst_tx_d", 64'(rmii_tx_d), 64'd0);
    check("rst_tx_empty", 64'(host_if.tx_empty), 64'd1);
    check("rst_rx", {31'd0, host_if.rx_full, host_if.rx_buf}, 64'd0);
    check("rst_mdio", {61'd0, mdc, mdio_o, mdio_oe}, 64'b010);
    check("rst_md", {47'd0, host_if.MD_done, host_if.MD_data_from}, 64'd0);
    rst = 1'b0;
    tick();

    // single word, with a stray tx_valid mid-frame that must be ignored
    host_if.tx_buf = 32'h9229C2C3; host_if.tx_valid = 1'b1;
    tick();
    host_if.tx_valid = 1'b0; host_if.tx_buf = 32'hDEADBEEF;
    got32 = '0; en_all = 1'b1;
    for (int i = 0; i < 16; i++) begin
      got32  = {got32[29:0], rmii_tx_d};
      en_all = en_all & rmii_tx_en;
      host_if.tx_valid = (i == 5);
      if (i != 15) tick();
    end
    host_if.tx_valid = 1'b0;
    check("tx_single_word", 64'(got32), 64'h9229C2C3);
    check("tx_single_en", 64'(en_all), 64'd1);
    tick();
    check("tx_single_end", {61'd0, rmii_tx_en, rmii_tx_d}, 64'd0);
    $display("tx single word %h", got32);

    // chained words
    tick();
    host_if.tx_buf = 32'h9229C2C3; host_if.tx_valid = 1'b1;
    tick();
    host_if.tx_valid = 1'b0; host_if.tx_buf = 32'h4F524860; host_if.tx_new_data = 1'b1;
    got64 = '0; en_all = 1'b1; e15 = 1'b1; e16 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      got64  = {got64[61:0], rmii_tx_d};
      en_all = en_all & rmii_tx_en;
      if (i == 1) begin
        check("tx_chain_empty_after_load", 64'(host_if.tx_empty), 64'd0);
        host_if.tx_new_data = 1'b0;
      end
      if (i == 15) e15 = host_if.tx_empty;
      if (i == 16) e16 = host_if.tx_empty;
      if (i != 31) tick();
    end
    check("tx_chain_words", got64, 64'h9229C2C3_4F524860);
    check("tx_chain_en", 64'(en_all), 64'd1);
    check("tx_chain_empty_handover", {62'd0, e15, e16}, 64'b01);
    tick();
    check("tx_chain_end", {61'd0, rmii_tx_en, rmii_tx_d}, 64'd0);
    $display("tx chained words %h", got64);

    // receive
    cnt_before = rx_full_cnt;
    send_rx_word(32'h9229C2C3, 16, -1);
    rmii_crs_dv = 1'b0;
    check("rx_full_pulse", 64'(host_if.rx_full), 64'd1);
    check("rx_word", 64'(host_if.rx_buf), 64'h9229C2C3);
    tick();
    check("rx_full_one_cycle", 64'(host_if.rx_full), 64'd0);
    $display("rx word %h", host_if.rx_buf);

    send_rx_word(32'h12345678, 10, -1);
    rmii_crs_dv = 1'b0;
    repeat (20) tick();
    check("rx_partial_buf", 64'(host_if.rx_buf), 64'h9229C2C3);
    $display("rx partial word dropped");

    send_rx_word(32'hA5A5A5A5, 16, 3);
    check("rx_err_no_pulse", 64'(host_if.rx_full), 64'd0);
    rmii_crs_dv = 1'b0;
    tick();
    send_rx_word(32'h0F0F1234, 16, -1);
    rmii_crs_dv = 1'b0;
    check("rx_after_err", {31'd0, host_if.rx_full, host_if.rx_buf}, {31'd0, 1'b1, 32'h0F0F1234});
    tick();
    check("rx_pulse_count", 64'(rx_full_cnt - cnt_before), 64'd2);
    $display("rx word %h after error", host_if.rx_buf);

    // MDIO write
    cnt_before = md_done_cnt;
    host_if.MD_mode = 1'b1; host_if.MD_addr = 5'h1B; host_if.MD_reg_addr = 5'h1B;
    host_if.MD_data_to = 16'hCC33; host_if.MD_start = 1'b1;
    tick();
    host_if.MD_start = 1'b0;
    got64 = '0; oe64 = '0; all_ok = 1'b1; first_n = 0;
    for (int i = 0; i < 64; i++) begin
      wait_mdc_rise(ok, n);
      all_ok = all_ok & ok;
      if (i == 0) first_n = n;
      got64 = {got64[62:0], mdio_o};
      oe64  = {oe64[62:0], mdio_oe};
    end
    check("md_wr_rises", 64'(all_ok), 64'd1);
    check("md_wr_first_rise", 64'(first_n), 64'd8);
    check("md_wr_frame", got64, 64'hFFFFFFFF_5DEECC33);
    check("md_wr_oe", oe64, 64'hFFFFFFFF_FFFFFFFF);
    repeat (7) tick();
    check("md_wr_done_early", 64'(host_if.MD_done), 64'd0);
    tick();
    check("md_wr_done", 64'(host_if.MD_done), 64'd1);
    tick();
    check("md_wr_idle", {59'd0, host_if.MD_done, mdc, mdio_o, mdio_oe, 1'b0}, 64'b00100);
    check("md_wr_no_rdata", 64'(host_if.MD_data_from), 64'd0);
    check("md_wr_done_count", 64'(md_done_cnt - cnt_before), 64'd1);
    $display("mdio write frame %h", got64);

    // MDIO read, PHY returns A5A5
    cnt_before = md_done_cnt;
    rd_val = 16'hA5A5;
    host_if.MD_mode = 1'b0; host_if.MD_addr = 5'h01; host_if.MD_reg_addr = 5'h02;
    host_if.MD_start = 1'b1;
    tick();
    host_if.MD_start = 1'b0;
    got64 = '0; oe64 = '0; all_ok = 1'b1;
    for (int i = 0; i < 64; i++) begin
      mdio_i = (i >= 48) ? rd_val[63-i] : 1'b1;
      wait_mdc_rise(ok, n);
      all_ok = all_ok & ok;
      got64 = {got64[62:0], mdio_o};
      oe64  = {oe64[62:0], mdio_oe};
    end
    mdio_i = 1'b1;
    check("md_rd_rises", 64'(all_ok), 64'd1);
    check("md_rd_header", 64'(got64[63:18]), 64'({32'hFFFFFFFF, 2'b01, 2'b10, 5'h01, 5'h02}));
    check("md_rd_oe", oe64, 64'hFFFFFFFF_FFFC0000);
    repeat (8) tick();
    check("md_rd_done", {47'd0, host_if.MD_done, host_if.MD_data_from}, {47'd0, 1'b1, 16'hA5A5});
    tick();
    check("md_rd_done_count", 64'(md_done_cnt - cnt_before), 64'd1);
    $display("mdio read data %h", host_if.MD_data_from);

    // reset in the middle of TX and an MDIO write
    cnt_before = md_done_cnt;
    host_if.tx_buf = 32'hFFFFFFFF; host_if.tx_valid = 1'b1;
    host_if.MD_mode = 1'b1; host_if.MD_start = 1'b1;
    tick();
    host_if.tx_valid = 1'b0; host_if.MD_start = 1'b0;
    repeat (9) tick();
    check("mid_busy", {62'd0, rmii_tx_en, mdc}, 64'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_outputs", {58'd0, rmii_tx_en, rmii_tx_d, mdc, mdio_o, mdio_oe}, 64'b000010);
    check("mid_rst_tx_empty", 64'(host_if.tx_empty), 64'd1);
    repeat (1100) tick();
    check("mid_rst_no_done", 64'(md_done_cnt - cnt_before), 64'd0);
    check("mid_rst_quiet", {62'd0, rmii_tx_en, mdc}, 64'd0);
    $display("reset mid-operation aborted activity");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
